// File: rtl/mux_stream_sel_if.sv
// Handshake bundle between the lane sources, the stream selector and the
// downstream consumer. The master drives inputs and consumes the output word.
interface mux_stream_sel_if #(
  parameter int NUM_INP = 31,
  parameter int WIDTH   = 2,
  parameter int SEL_W   = 5
);
  logic                       mode;
  logic [SEL_W-1:0]           sel;
  logic [NUM_INP*WIDTH-1:0]   in_data;
  logic [NUM_INP-1:0]         in_valid;
  logic [NUM_INP-1:0]         in_ready;
  logic [WIDTH-1:0]           out_data;
  logic [SEL_W-1:0]           out_chan;
  logic                       out_valid;
  logic                       out_ready;
  logic                       sel_err;
  logic [7:0]                 err_cnt;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_chan, out_valid, sel_err, err_cnt
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_chan, out_valid, sel_err, err_cnt
  );
endinterface

// File: rtl/mux_stream_sel.sv
// Registered N-way stream selector: directed or round-robin channel pick into
// a one-entry output register, with out-of-range select reporting.
module mux_stream_sel #(
  parameter int NUM_INP = 31,
  parameter int WIDTH   = 2,
  parameter int SEL_W   = 5
) (
  input logic             clk,
  input logic             rst,
  mux_stream_sel_if.slave bus
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_INP - 1);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_hit;
  logic [SEL_W-1:0] cand;
  logic             cand_hit;
  logic             sel_ok;
  logic             load_ok;
  logic             grant;
  logic             xfer;
  logic [WIDTH-1:0] cand_data;
  logic [SEL_W-1:0] ptr_next;
  logic             bad_sel;
  int               rr_j;

  logic [WIDTH-1:0] out_data_q;
  logic [SEL_W-1:0] out_chan_q;
  logic             out_valid_q;
  logic             sel_err_q;
  logic [7:0]       err_cnt_q;

  // The output register may accept a word when empty or being drained now.
  assign load_ok = !out_valid_q || bus.out_ready;
  assign sel_ok  = 32'(bus.sel) < 32'(NUM_INP);

  // Round-robin scan from ptr upward with wrap; walking offsets downward lets
  // the nearest valid channel overwrite farther ones.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = ptr;
    rr_j   = 0;
    for (int k = NUM_INP - 1; k >= 0; k--) begin
      rr_j = int'(ptr) + k;
      if (rr_j >= NUM_INP) rr_j = rr_j - NUM_INP;
      if (bus.in_valid[rr_j]) begin
        rr_hit = 1'b1;
        rr_idx = SEL_W'(rr_j);
      end
    end
  end

  assign cand     = bus.mode ? rr_idx : bus.sel;
  assign cand_hit = bus.mode ? rr_hit : sel_ok;
  assign grant    = !rst && cand_hit && load_ok;
  assign xfer     = grant && bus.in_valid[cand];
  assign cand_data = bus.in_data[cand*WIDTH +: WIDTH];
  assign ptr_next = (cand == LAST) ? '0 : cand + 1'b1;
  assign bad_sel  = !bus.mode && !sel_ok && load_ok;

  // One-hot ready: only the candidate lane sees the grant.
  for (genvar i = 0; i < NUM_INP; i++) begin : g_rdy
    assign bus.in_ready[i] = grant && (cand == SEL_W'(i));
  end

  // Output register, round-robin pointer and select-error bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr         <= '0;
      sel_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      if (xfer) begin
        out_data_q  <= cand_data;
        out_chan_q  <= cand;
        out_valid_q <= 1'b1;
        if (bus.mode) ptr <= ptr_next;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      sel_err_q <= bad_sel;
      if (bad_sel && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sel_err   = sel_err_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_mux_stream_sel.sv
// Bench for mux_stream_sel: directed scenarios plus random traffic, all checked
// against a cycle-level reference model of the selection rules.
module tb_mux_stream_sel;
  localparam int N = 31;
  localparam int W = 2;
  localparam int S = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  // Reference model state
  logic         m_ov;
  logic [W-1:0] m_data;
  int           m_chan;
  int           m_ptr;
  logic         m_err;
  int           m_cnt;

  logic [W-1:0] d_hold;

  mux_stream_sel_if #(.NUM_INP(N), .WIDTH(W), .SEL_W(S)) bus ();

  mux_stream_sel #(.NUM_INP(N), .WIDTH(W), .SEL_W(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] rnd_data();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[N*W-1:0];
  endfunction

  // One clock: check combinational ready and registered outputs against the
  // model, then advance the model across the edge.
  task automatic cycle();
    int g;
    logic lok, xf;
    logic [N-1:0] er;
    logic         n_ov, n_err;
    logic [W-1:0] n_data;
    int           n_chan, n_ptr, n_cnt;
    #1;
    lok = !m_ov || bus.out_ready;
    g = -1;
    if (!rst && lok) begin
      if (!bus.mode) begin
        if (int'(bus.sel) < N) g = int'(bus.sel);
      end else begin
        for (int k = 0; k < N; k++)
          if (g < 0 && bus.in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("in_ready",  64'(bus.in_ready),  64'(er));
    chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
    chk("out_data",  64'(bus.out_data),  64'(m_data));
    chk("out_chan",  64'(bus.out_chan),  64'(m_chan));
    chk("sel_err",   64'(bus.sel_err),   64'(m_err));
    chk("err_cnt",   64'(bus.err_cnt),   64'(m_cnt));
    n_ov = m_ov; n_data = m_data; n_chan = m_chan; n_ptr = m_ptr; n_cnt = m_cnt;
    xf = (g >= 0) && bus.in_valid[g];
    if (rst) begin
      n_ov = 0; n_data = '0; n_chan = 0; n_ptr = 0; n_err = 0; n_cnt = 0;
    end else begin
      if (xf) begin
        n_ov = 1; n_data = bus.in_data[g*W +: W]; n_chan = g;
        if (bus.mode) n_ptr = (g + 1) % N;
      end else if (m_ov && bus.out_ready) n_ov = 0;
      n_err = !bus.mode && (int'(bus.sel) >= N) && lok;
      if (n_err && n_cnt < 255) n_cnt++;
    end
    @(posedge clk);
    #1;
    m_ov = n_ov; m_data = n_data; m_chan = n_chan; m_ptr = n_ptr;
    m_err = n_err; m_cnt = n_cnt;
  endtask

  initial begin
    bus.mode = 0; bus.sel = '0; bus.in_data = '0; bus.in_valid = '0; bus.out_ready = 1;
    rst = 1;
    @(posedge clk); #1;
    m_ov = 0; m_data = '0; m_chan = 0; m_ptr = 0; m_err = 0; m_cnt = 0;
    cycle();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_err_cnt",   64'(bus.err_cnt),   64'd0);
    rst = 0;

    // Directed: channel 3, then the top reachable index 30
    bus.in_data = rnd_data(); bus.in_data[3*W +: W] = 2'b10;
    bus.in_valid = '0; bus.in_valid[3] = 1; bus.sel = 5'd3;
    cycle();
    chk("dir3_data",  64'(bus.out_data),  64'd2);
    chk("dir3_chan",  64'(bus.out_chan),  64'd3);
    chk("dir3_valid", 64'(bus.out_valid), 64'd1);
    bus.in_data[30*W +: W] = 2'b11; bus.in_valid[30] = 1; bus.sel = 5'd30;
    cycle();
    chk("dir30_data", 64'(bus.out_data), 64'd3);
    chk("dir30_chan", 64'(bus.out_chan), 64'd30);

    // Drain, then out-of-range select held until the counter saturates
    bus.in_valid = '0; bus.sel = '0;
    cycle();
    bus.in_valid = '1; bus.sel = 5'd31;
    #1;
    chk("oor_ready", 64'(bus.in_ready), 64'd0);
    cycle();
    chk("oor_sel_err", 64'(bus.sel_err),   64'd1);
    chk("oor_err_cnt", 64'(bus.err_cnt),   64'd1);
    chk("oor_valid",   64'(bus.out_valid), 64'd0);
    for (int i = 0; i < 299; i++) cycle();
    chk("oor_sat", 64'(bus.err_cnt), 64'd255);

    // Backpressure
    bus.sel = 5'd7; bus.in_data = rnd_data();
    d_hold = bus.in_data[7*W +: W];
    cycle();
    bus.out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = rnd_data();
      cycle();
      chk("bp_data", 64'(bus.out_data), 64'(d_hold));
      chk("bp_chan", 64'(bus.out_chan), 64'd7);
    end
    bus.out_ready = 1; bus.in_data = rnd_data();
    d_hold = bus.in_data[7*W +: W];
    cycle();
    chk("bp_release", 64'(bus.out_data), 64'(d_hold));

    // Round-robin fairness over all channels, then two sparse channels
    bus.mode = 1; bus.in_valid = '1; bus.sel = 5'd31;
    for (int k = 0; k < N + 2; k++) begin
      bus.in_data = rnd_data();
      cycle();
      chk("rr_all", 64'(bus.out_chan), 64'(k % N));
    end
    bus.in_valid = '0; bus.in_valid[5] = 1; bus.in_valid[20] = 1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("rr_sparse", 64'(bus.out_chan), (k % 2 == 0) ? 64'd5 : 64'd20);
    end

    // Reset mid-stream with ptr at 12
    rst = 1; cycle(); rst = 0;
    bus.in_valid = '1;
    for (int k = 0; k < 12; k++) cycle();
    rst = 1;
    cycle();
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_chan",  64'(bus.out_chan),  64'd0);
    chk("mid_rst_data",  64'(bus.out_data),  64'd0);
    rst = 0;
    cycle();
    chk("post_rst_chan",  64'(bus.out_chan),  64'd0);
    chk("post_rst_valid", 64'(bus.out_valid), 64'd1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bus.mode      = ($urandom_range(0, 3) != 0) ? bus.mode : ~bus.mode;
      bus.sel       = S'($urandom_range(0, 31));
      bus.in_data   = rnd_data();
      bus.in_valid  = ($urandom_range(0, 3) == 0) ? N'($urandom) & N'($urandom) : N'($urandom);
      bus.out_ready = $urandom_range(0, 3) != 0;
      rst           = $urandom_range(0, 49) == 0;
      cycle();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_stream_sel.md
# mux_stream_sel

Parametrised, registered successor to the team's flat 31-way 2-bit selector. It picks one of `NUM_INP` input channels of `WIDTH` bits and moves the word into a one-entry output register, with valid/ready handshakes on every channel. Selection is either directed (explicit `sel`) or round-robin over valid channels. Out-of-range selects are reported, not silently zeroed. The block sits between the lane sources and the downstream consumer on the single design clock.

## Interface
- `NUM_INP`, 31: number of input channels, 2..32.
- `WIDTH`, 2: data width per channel.
- `SEL_W`, 5: select/channel-index width; requires 2^SEL_W >= NUM_INP.

- `clk`  in  1  design clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mode`  in  1  0 = directed (use `sel`), 1 = round-robin.
- `sel`  in  SEL_W  directed-mode channel index.
- `in_data`  in  NUM_INP*WIDTH  packed inputs; channel i is bits [i*WIDTH +: WIDTH].
- `in_valid`  in  NUM_INP  per-channel valid.
- `in_ready`  out  NUM_INP  per-channel ready (combinational), at most one bit high.
- `out_data`  out  WIDTH  registered output word.
- `out_chan`  out  SEL_W  index of the channel that supplied `out_data`.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  downstream accepts the word.
- `sel_err`  out  1  one-cycle pulse: a directed select was out of range.
- `err_cnt`  out  8  saturating count of `sel_err` pulses.

## Operation
- `load_ok = !out_valid || out_ready`. No channel is granted unless `load_ok` is high.
- Directed mode (`mode`=0):
  - If `sel` < NUM_INP, the candidate is `sel`, and `in_ready[sel] = load_ok`.
  - Every index 0..NUM_INP-1 is reachable, including the top index.
  - If `sel` >= NUM_INP, no `in_ready` is asserted.
  - If `load_ok` is also high in that cycle, `sel_err` pulses in the next cycle and `err_cnt` increments, saturating at 255.
- Round-robin mode (`mode`=1):
  - Pointer `ptr` ranges over 0..NUM_INP-1.
  - The grant goes to the first i with `in_valid[i]`, scanning from `ptr` upward and wrapping past NUM_INP-1 to 0.
  - `in_ready[grant] = load_ok`.
  - On a transfer, `ptr` is set to grant+1, wrapping NUM_INP-1 to 0. Otherwise `ptr` holds.
  - `sel` is ignored and `sel_err` is never raised.
- Transfer rule: a transfer on channel i occurs when `in_valid[i] && in_ready[i]`. On the next edge `out_data` takes that channel's word, `out_chan` takes i, and `out_valid` is set to 1.
- If there is no transfer and `out_valid && out_ready`, `out_valid` clears. `out_data` and `out_chan` hold their last values.
- While `out_valid && !out_ready`, `out_data` and `out_chan` stay stable and all `in_ready` are 0.
- A `mode` change takes effect in the same cycle. `ptr` is preserved across mode changes.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_chan`=0, `sel_err`=0, `err_cnt`=0, `ptr`=0. `in_ready` is all 0 while `rst` is high.
- Reset mid-operation discards any held word, with no output handshake. The first grant after reset is evaluated in the cycle `rst` falls low.
- Latency: 1 cycle from input handshake to `out_valid`.
- Throughput: 1 word/cycle when `out_ready` is held high. Drain and refill in the same cycle are allowed.
- `in_ready` depends combinationally on `sel`, `mode`, `in_valid` (round-robin mode only), `out_valid` and `out_ready`. The data path has no other combinational path to the output.
- `sel_err` is registered: high for exactly one cycle per offending cycle.

## Test plan
- Directed path, defaults:
  - `sel`=3, channel 3 = 2'b10, `in_valid[3]`=1, `out_ready`=1 -> next cycle `out_data`=2'b10, `out_chan`=3, `out_valid`=1.
  - `sel`=30, channel 30 = 2'b11 -> `out_data`=2'b11, `out_chan`=30.
- Out-of-range select: `sel`=31, `in_valid`=all ones, `out_valid`=0 -> `in_ready`=0; next cycle `sel_err`=1 and `err_cnt`=1, `out_valid` stays 0. Hold for 300 cycles -> `err_cnt`=255.
- Backpressure:
  - Load a word, then `out_ready`=0 for 5 cycles with new input data -> `out_data` and `out_chan` unchanged, `in_ready`=0.
  - Raise `out_ready` -> new word appears 1 cycle later.
- Round-robin fairness: `mode`=1, all `in_valid`=1, `out_ready`=1 -> `out_chan` sequence 0,1,...,30,0,1. With only channels 5 and 20 valid -> alternates 5,20,5,20.
- Reset mid-stream: assert `rst` for 1 cycle while `out_valid`=1, `ptr`=12 -> all outputs at reset values. In round-robin mode with all channels valid, the next grant is channel 0.
